// File: rtl/acumulador_de_digitos_pkg.sv
// Shared types and key codes for the digit accumulator.
// Optional inactivity timeout is enabled with `define ACUMULADOR_TIMEOUT_EN.
package acumulador_pkg;

  typedef enum logic [1:0] {
    VAZIO,
    COLETANDO,
    CHEIO
  } estado_t;

  localparam logic [3:0] TECLA_ENTER = 4'hE;
  localparam logic [3:0] TECLA_CLEAR = 4'hF;

  function automatic logic eh_digito(logic [3:0] tecla);
    return (tecla <= 4'd9);
  endfunction

endpackage

// File: rtl/acumulador_de_digitos_if.sv
// Keypad-side and result-side signals of the digit accumulator.
// master = keypad/consumer side, slave = accumulator.
interface acumulador_de_digitos_if #(
  parameter int N_DIGITOS = 4
);
  logic [3:0]                       tecla_value;
  logic                             tecla_valid;
  logic [4*N_DIGITOS-1:0]           buffer_out;
  logic [$clog2(N_DIGITOS+1)-1:0]   num_digitos;
  logic [4*N_DIGITOS-1:0]           senha_out;
  logic                             senha_valid;
  logic                             erro;
  logic                             timeout_pulse;

  modport master (
    output tecla_value, tecla_valid,
    input  buffer_out, num_digitos, senha_out, senha_valid, erro, timeout_pulse
  );

  modport slave (
    input  tecla_value, tecla_valid,
    output buffer_out, num_digitos, senha_out, senha_valid, erro, timeout_pulse
  );
endinterface

// File: rtl/detector_de_borda.sv
// 1-bit rising-edge detector; the registered copy resets to VALOR_RESET so a
// level already high when reset releases does not count as an edge.
module detector_de_borda #(
  parameter logic VALOR_RESET = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic borda
);

  logic tv_q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tv_q_reg <= VALOR_RESET;
    else     tv_q_reg <= d;
  end

  assign borda = d & ~tv_q_reg;

endmodule

// File: rtl/acumulador_de_digitos.sv
// Accumulates keypad digits into a packed BCD buffer; E commits, F clears.
// Define ACUMULADOR_TIMEOUT_EN to discard stale entries after TIMEOUT_CICLOS.
module acumulador_de_digitos
  import acumulador_pkg::*;
#(
  parameter int N_DIGITOS      = 4,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input logic               clk,
  input logic               rst,
  acumulador_de_digitos_if.slave bus
);

  localparam int W  = 4 * N_DIGITOS;
  localparam int CW = $clog2(N_DIGITOS + 1);
  localparam logic [CW-1:0] CONT_CHEIO = CW'(N_DIGITOS);

  if (N_DIGITOS < 1 || N_DIGITOS > 8 || TIMEOUT_CICLOS < 2) begin : g_param_invalido
    $error("acumulador_de_digitos: N_DIGITOS must be 1..8 and TIMEOUT_CICLOS >= 2");
  end

  estado_t         estado_reg;
  logic [W-1:0]    buffer_reg;
  logic [CW-1:0]   cont_reg;
  logic [W-1:0]    senha_reg;
  logic            senha_valid_reg;
  logic            erro_reg;
  logic            aceita;

  detector_de_borda #(.VALOR_RESET(1'b1)) u_borda (
    .clk   (clk),
    .rst   (rst),
    .d     (bus.tecla_valid),
    .borda (aceita)
  );

`ifdef ACUMULADOR_TIMEOUT_EN
  // TIMEOUT_CICLOS >= 2 keeps this width at least one bit.
  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);
  logic [TW-1:0] timer_reg;
  logic          timeout_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_reg      <= VAZIO;
      buffer_reg      <= '0;
      cont_reg        <= '0;
      senha_reg       <= '0;
      senha_valid_reg <= 1'b0;
      erro_reg        <= 1'b0;
`ifdef ACUMULADOR_TIMEOUT_EN
      timer_reg       <= '0;
      timeout_reg     <= 1'b0;
`endif
    end else begin
      senha_valid_reg <= 1'b0;
      erro_reg        <= 1'b0;
`ifdef ACUMULADOR_TIMEOUT_EN
      timeout_reg     <= 1'b0;
`endif
      if (aceita) begin
`ifdef ACUMULADOR_TIMEOUT_EN
        timer_reg <= '0;
`endif
        if (eh_digito(bus.tecla_value)) begin
          if (estado_reg == CHEIO) begin
            erro_reg <= 1'b1;
          end else begin
            // Shift happens only below capacity, so no digit falls off the top.
            buffer_reg <= (buffer_reg << 4) | W'(bus.tecla_value);
            cont_reg   <= cont_reg + 1'b1;
            estado_reg <= ((cont_reg + 1'b1) == CONT_CHEIO) ? CHEIO : COLETANDO;
          end
        end else if (bus.tecla_value == TECLA_ENTER) begin
          if (cont_reg != '0) begin
            senha_reg       <= buffer_reg;
            senha_valid_reg <= 1'b1;
            buffer_reg      <= '0;
            cont_reg        <= '0;
            estado_reg      <= VAZIO;
          end
        end else if (bus.tecla_value == TECLA_CLEAR) begin
          buffer_reg <= '0;
          cont_reg   <= '0;
          estado_reg <= VAZIO;
        end else begin
          erro_reg <= 1'b1;
        end
      end
`ifdef ACUMULADOR_TIMEOUT_EN
      else if (estado_reg == VAZIO) begin
        timer_reg <= '0;
      end else if (timer_reg == TIMER_MAX) begin
        buffer_reg  <= '0;
        cont_reg    <= '0;
        estado_reg  <= VAZIO;
        timeout_reg <= 1'b1;
        timer_reg   <= '0;
      end else begin
        timer_reg <= timer_reg + 1'b1;
      end
`endif
    end
  end

  assign bus.buffer_out  = buffer_reg;
  assign bus.num_digitos = cont_reg;
  assign bus.senha_out   = senha_reg;
  assign bus.senha_valid = senha_valid_reg;
  assign bus.erro        = erro_reg;
`ifdef ACUMULADOR_TIMEOUT_EN
  assign bus.timeout_pulse = timeout_reg;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

endmodule
